// File: rtl/clock_time_counters.sv
// ---------------------------------------------------------------------------
// clock_time_counters
//
// Timekeeping datapath for the clock. It holds seconds, minutes and hours as
// packed BCD digit pairs and responds to the counter-control commands issued
// by the control unit:
//   - run mode : seconds advance on the 1 Hz tick and carry ripples through
//                minutes and hours within the same edge;
//   - set mode : each enabled field advances on the setting tick on its own,
//                with no carry between fields.
//
// Parameters
//   HOUR_MODE_24  1 = hours 00..23 (reset 00), 0 = hours 01..12 (reset 12)
//
// Ports
//   i_Clock                      system clock, rising edge
//   i_Reset_n                    synchronous active-low reset
//   i_Tick_1Hz                   one-cycle pulse per second
//   i_Tick_Set                   one-cycle pulse at the setting rate
//   i_Counters_Reset             clear the seconds field (highest command)
//   i_Counters_Enable_Increment  0 = run mode, 1 = set mode
//   i_Counters_Enable_Count      field enables [0] sec, [1] min, [2] hours
//   o_Sec_Ones/o_Sec_Tens        seconds BCD digits
//   o_Min_Ones/o_Min_Tens        minutes BCD digits
//   o_Hour_Ones/o_Hour_Tens      hours BCD digits
//   o_Rollover                   one-cycle pulse on a full-day wrap
//   o_Second_Blink               toggles on every accepted seconds increment
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module clock_time_counters #(
  parameter int unsigned HOUR_MODE_24 = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tick_1Hz,
  input  logic       i_Tick_Set,
  input  logic       i_Counters_Reset,
  input  logic       i_Counters_Enable_Increment,
  input  logic [2:0] i_Counters_Enable_Count,
  output logic [3:0] o_Sec_Ones,
  output logic [3:0] o_Sec_Tens,
  output logic [3:0] o_Min_Ones,
  output logic [3:0] o_Min_Tens,
  output logic [3:0] o_Hour_Ones,
  output logic [3:0] o_Hour_Tens,
  output logic       o_Rollover,
  output logic       o_Second_Blink
);

  localparam bit MODE24 = (HOUR_MODE_24 != 0);

  // Hours value after reset, and the last hour of the day: the hour whose
  // carry-in marks the start of a new day (23 -> 00, or 11 -> 12 in 12h mode).
  localparam logic [7:0] HOUR_RESET = MODE24 ? 8'h00 : 8'h12;
  localparam logic [7:0] HOUR_LAST  = MODE24 ? 8'h23 : 8'h12;
  localparam logic [7:0] HOUR_FIRST = MODE24 ? 8'h00 : 8'h01;
  localparam logic [7:0] DAY_END    = MODE24 ? 8'h23 : 8'h11;

  // Field enables, named for readability.
  logic en_sec, en_min, en_hour;
  assign en_sec  = i_Counters_Enable_Count[0];
  assign en_min  = i_Counters_Enable_Count[1];
  assign en_hour = i_Counters_Enable_Count[2];

  // Packed BCD pairs: [7:4] tens digit, [3:0] ones digit.
  logic [7:0] sec_q,   sec_d;
  logic [7:0] min_q,   min_d;
  logic [7:0] hour_q,  hour_d;
  logic       roll_q,  roll_d;
  logic       blink_q, blink_d;

  // Increment of a 00..59 field. The wrap is decided on the full two-digit
  // value; otherwise ones 9 -> 0 bumps the tens digit.
  function automatic logic [7:0] inc_sixty(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (v == 8'h59) begin
      tens = 4'd0;
      ones = 4'd0;
    end else if (ones >= 4'd9) begin
      tens = tens + 4'd1;
      ones = 4'd0;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Increment of the hours field. 24h: 23 -> 00. 12h: 12 -> 01, and
  // 11 -> 12 is an ordinary BCD step.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (v == HOUR_LAST) begin
      tens = HOUR_FIRST[7:4];
      ones = HOUR_FIRST[3:0];
    end else if (ones >= 4'd9) begin
      tens = tens + 4'd1;
      ones = 4'd0;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Run-mode carry chain terms. A carry only exists when the lower field
  // actually wrapped on this edge; a disabled field drops it.
  logic run_sec_step;
  logic run_min_step;
  logic run_hour_step;

  assign run_sec_step  = i_Tick_1Hz && en_sec;
  assign run_min_step  = run_sec_step && (sec_q == 8'h59) && en_min;
  assign run_hour_step = run_min_step && (min_q == 8'h59) && en_hour;

  // Next-state selection. Priority: seconds clear > set mode > run mode.
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    roll_d  = 1'b0;
    blink_d = blink_q;

    if (i_Counters_Reset) begin
      // Clear seconds only; a coinciding tick produces no carry or rollover.
      sec_d = 8'h00;
    end else if (i_Counters_Enable_Increment) begin
      // Set mode: independent per-field steps, 1 Hz tick and blink frozen.
      if (i_Tick_Set) begin
        if (en_sec) begin
          sec_d = inc_sixty(sec_q);
        end
        if (en_min) begin
          min_d = inc_sixty(min_q);
        end
        if (en_hour) begin
          hour_d = inc_hour(hour_q);
        end
      end
    end else begin
      // Run mode: the setting tick is ignored.
      if (run_sec_step) begin
        sec_d   = inc_sixty(sec_q);
        blink_d = ~blink_q;
      end
      if (run_min_step) begin
        min_d = inc_sixty(min_q);
      end
      if (run_hour_step) begin
        hour_d = inc_hour(hour_q);
        // Leaving the last hour of the day through the full chain is the
        // start of a new day (run_hour_step already implies all enables).
        roll_d = (hour_q == DAY_END);
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hour_q  <= HOUR_RESET;
      roll_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      roll_q  <= roll_d;
      blink_q <= blink_d;
    end
  end

  assign o_Sec_Ones     = sec_q[3:0];
  assign o_Sec_Tens     = sec_q[7:4];
  assign o_Min_Ones     = min_q[3:0];
  assign o_Min_Tens     = min_q[7:4];
  assign o_Hour_Ones    = hour_q[3:0];
  assign o_Hour_Tens    = hour_q[7:4];
  assign o_Rollover     = roll_q;
  assign o_Second_Blink = blink_q;

endmodule

// File: tb/tb_clock_time_counters.sv
// ---------------------------------------------------------------------------
// tb_clock_time_counters
//
// Two instances share one stimulus stream: index 0 runs 24h mode, index 1
// runs 12h mode. A reference model holds each clock as plain integers
// (hours, minutes, seconds) and applies the command rules with arithmetic.
// ---------------------------------------------------------------------------
module tb_clock_time_counters;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       t1, ts, cr, inc;
  logic [2:0] en;

  logic [3:0] so[2], st[2], mo[2], mt[2], ho[2], ht[2];
  logic       roll[2], blink[2];

  clock_time_counters #(.HOUR_MODE_24(1)) dut24 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Tick_1Hz(t1), .i_Tick_Set(ts),
    .i_Counters_Reset(cr), .i_Counters_Enable_Increment(inc),
    .i_Counters_Enable_Count(en),
    .o_Sec_Ones(so[0]), .o_Sec_Tens(st[0]), .o_Min_Ones(mo[0]),
    .o_Min_Tens(mt[0]), .o_Hour_Ones(ho[0]), .o_Hour_Tens(ht[0]),
    .o_Rollover(roll[0]), .o_Second_Blink(blink[0])
  );

  clock_time_counters #(.HOUR_MODE_24(0)) dut12 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Tick_1Hz(t1), .i_Tick_Set(ts),
    .i_Counters_Reset(cr), .i_Counters_Enable_Increment(inc),
    .i_Counters_Enable_Count(en),
    .o_Sec_Ones(so[1]), .o_Sec_Tens(st[1]), .o_Min_Ones(mo[1]),
    .o_Min_Tens(mt[1]), .o_Hour_Ones(ho[1]), .o_Hour_Tens(ht[1]),
    .o_Rollover(roll[1]), .o_Second_Blink(blink[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int ms[2], mm[2], mh[2];
  bit mroll[2], mblink[2];

  function automatic int next_hour(input int k, input int h);
    return (k == 0) ? (h + 1) % 24 : (h % 12) + 1;
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ms[k] = 0; mm[k] = 0; mh[k] = (k == 0) ? 0 : 12;
        mroll[k] = 0; mblink[k] = 0;
      end else begin
        mroll[k] = 0;
        if (cr) begin
          ms[k] = 0;
        end else if (inc) begin
          if (ts) begin
            if (en[0]) ms[k] = (ms[k] + 1) % 60;
            if (en[1]) mm[k] = (mm[k] + 1) % 60;
            if (en[2]) mh[k] = next_hour(k, mh[k]);
          end
        end else if (t1 && en[0]) begin
          mblink[k] = !mblink[k];
          if (ms[k] < 59) ms[k] = ms[k] + 1;
          else begin
            ms[k] = 0;
            if (en[1]) begin
              if (mm[k] < 59) mm[k] = mm[k] + 1;
              else begin
                mm[k] = 0;
                if (en[2]) begin
                  // A new day starts when leaving 23 (24h) or 11 (12h).
                  mroll[k] = (mh[k] == ((k == 0) ? 23 : 11));
                  mh[k] = next_hour(k, mh[k]);
                end
              end
            end
          end
        end
      end
    end
  endfunction

  function automatic logic [23:0] exp_t(input int k);
    logic [3:0] d[6];
    d[0] = 4'(mh[k] / 10); d[1] = 4'(mh[k] % 10);
    d[2] = 4'(mm[k] / 10); d[3] = 4'(mm[k] % 10);
    d[4] = 4'(ms[k] / 10); d[5] = 4'(ms[k] % 10);
    return {d[0], d[1], d[2], d[3], d[4], d[5]};
  endfunction

  function automatic logic [23:0] got_t(input int k);
    return {ht[k], ho[k], mt[k], mo[k], st[k], so[k]};
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input bit a_rn, input bit a_t1, input bit a_ts,
                     input bit a_cr, input bit a_inc, input bit [2:0] a_en);
    rst_n = a_rn; t1 = a_t1; ts = a_ts; cr = a_cr; inc = a_inc; en = a_en;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ticks(input bit [2:0] a_en, input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 1, a_en);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc(0, 1, 1, 0, 0, 3'b111);
    cyc(0, 1, 1, 0, 1, 3'b111);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got_t(k), roll[k], blink[k]} !== {((k == 0) ? 24'h000000 : 24'h120000), 2'b00}) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h r%b b%b required %h r0 b0", k,
                 got_t(k), roll[k], blink[k], (k == 0) ? 24'h000000 : 24'h120000);
      end
    end
  endtask

  task automatic test_run_count();
    cyc(0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) begin
        cyc(1, (p == 0), 0, 0, 0, 3'b111);
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if ({got_t(k), roll[k], blink[k]} !== {exp_t(k), mroll[k], mblink[k]}) begin
            n_fail++;
            $display("FAIL run_count dut%0d tick%0d: got %h r%b b%b required %h r%b b%b",
                     k, i, got_t(k), roll[k], blink[k], exp_t(k), mroll[k], mblink[k]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got_t(k), blink[k]} !== {((k == 0) ? 24'h000100 : 24'h120100), 1'b0}) begin
        n_fail++;
        $display("FAIL run_count_end dut%0d: got %h b%b required %h b0", k,
                 got_t(k), blink[k], (k == 0) ? 24'h000100 : 24'h120100);
      end
    end
  endtask

  task automatic test_day_wrap();
    cyc(0, 0, 0, 0, 0, 3'b000);
    set_ticks(3'b100, 23);
    set_ticks(3'b010, 59);
    for (int i = 0; i < 59; i++) cyc(1, 1, 0, 0, 0, 3'b001);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got_t(k) !== ((k == 0) ? 24'h235959 : 24'h115959)) begin
        n_fail++;
        $display("FAIL day_preset dut%0d: got %h required %h", k, got_t(k),
                 (k == 0) ? 24'h235959 : 24'h115959);
      end
    end
    cyc(1, 1, 0, 0, 0, 3'b111);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got_t(k), roll[k]} !== {((k == 0) ? 24'h000000 : 24'h120000), 1'b1}) begin
        n_fail++;
        $display("FAIL day_wrap dut%0d: got %h r%b required %h r1", k, got_t(k),
                 roll[k], (k == 0) ? 24'h000000 : 24'h120000);
      end
    end
    cyc(1, 0, 0, 0, 0, 3'b111);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (roll[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL rollover_width dut%0d: got %b required 0", k, roll[k]);
      end
    end
    // 00:59:59 / 12:59:59 -> 01:00:00, not a day wrap.
    set_ticks(3'b010, 59);
    set_ticks(3'b001, 59);
    cyc(1, 1, 0, 0, 0, 3'b111);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got_t(k), roll[k]} !== {24'h010000, 1'b0}) begin
        n_fail++;
        $display("FAIL hour_wrap_no_roll dut%0d: got %h r%b required 010000 r0",
                 k, got_t(k), roll[k]);
      end
    end
  endtask

  task automatic test_set_mode();
    cyc(0, 0, 0, 0, 0, 3'b000);
    set_ticks(3'b010, 59);
    cyc(1, 1, 0, 0, 1, 3'b010);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got_t(k), blink[k]} !== {((k == 0) ? 24'h005900 : 24'h125900), 1'b0}) begin
        n_fail++;
        $display("FAIL set_ignores_1hz dut%0d: got %h b%b required %h b0", k,
                 got_t(k), blink[k], (k == 0) ? 24'h005900 : 24'h125900);
      end
    end
    cyc(1, 0, 1, 0, 1, 3'b010);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got_t(k), roll[k]} !== {((k == 0) ? 24'h000000 : 24'h120000), 1'b0}) begin
        n_fail++;
        $display("FAIL set_min_wrap dut%0d: got %h r%b required %h r0", k,
                 got_t(k), roll[k], (k == 0) ? 24'h000000 : 24'h120000);
      end
    end
  endtask

  task automatic test_seconds_clear();
    cyc(0, 0, 0, 0, 0, 3'b000);
    set_ticks(3'b010, 10);
    set_ticks(3'b001, 59);
    cyc(1, 1, 0, 1, 0, 3'b111);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({got_t(k), roll[k], blink[k]} !==
          {((k == 0) ? 24'h001000 : 24'h121000), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL seconds_clear dut%0d: got %h r%b b%b required %h r0 b0", k,
                 got_t(k), roll[k], blink[k], (k == 0) ? 24'h001000 : 24'h121000);
      end
    end
  endtask

  task automatic test_disabled_carry();
    cyc(0, 0, 0, 0, 0, 3'b000);
    set_ticks(3'b001, 59);
    cyc(1, 1, 0, 0, 0, 3'b001);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got_t(k) !== ((k == 0) ? 24'h000000 : 24'h120000)) begin
        n_fail++;
        $display("FAIL dropped_carry dut%0d: got %h required %h", k, got_t(k),
                 (k == 0) ? 24'h000000 : 24'h120000);
      end
    end
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 3'b111);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got_t(k) !== ((k == 0) ? 24'h000003 : 24'h120003)) begin
        n_fail++;
        $display("FAIL carry_not_deferred dut%0d: got %h required %h", k, got_t(k),
                 (k == 0) ? 24'h000003 : 24'h120003);
      end
    end
  endtask

  task automatic test_random();
    bit r_inc;
    r_inc = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) r_inc = !r_inc;
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 0),
          ($urandom_range(0, 1) == 0), ($urandom_range(0, 29) == 0), r_inc,
          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({got_t(k), roll[k], blink[k]} !== {exp_t(k), mroll[k], mblink[k]}) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got %h r%b b%b required %h r%b b%b",
                   k, i, got_t(k), roll[k], blink[k], exp_t(k), mroll[k], mblink[k]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; t1 = 1'b0; ts = 1'b0; cr = 1'b0; inc = 1'b0; en = 3'b000;
    test_reset();
    test_run_count();
    test_day_wrap();
    test_set_mode();
    test_seconds_clear();
    test_disabled_carry();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_counters.md
Name: clock_time_counters

Overview:
- Timekeeping datapath driven by the clock's control unit: the command responder for its counter-control outputs (reset, increment-mode, per-field count enables).
- Holds seconds, minutes and hours as BCD digit pairs.
- Advances on a 1 Hz tick in run mode and on a setting tick in set mode.
- Feeds BCD digits to the display path.

Parameters:
- HOUR_MODE_24, 1, 1 = hours 00..23 (reset 00); 0 = hours 01..12 (reset 12).

Ports:
- i_Clock  input  1  system clock; all state updates on rising edge
- i_Reset_n  input  1  reset; synchronous, active-low
- i_Tick_1Hz  input  1  one-cycle pulse, once per second
- i_Tick_Set  input  1  one-cycle pulse at setting rate (e.g. 2 Hz)
- i_Counters_Reset  input  1  clear seconds field
- i_Counters_Enable_Increment  input  1  0 = run mode, 1 = set mode
- i_Counters_Enable_Count  input  3  field enables: [0] seconds, [1] minutes, [2] hours
- o_Sec_Ones  output  4  BCD 0..9
- o_Sec_Tens  output  4  BCD 0..5
- o_Min_Ones  output  4  BCD 0..9
- o_Min_Tens  output  4  BCD 0..5
- o_Hour_Ones  output  4  BCD
- o_Hour_Tens  output  4  BCD 0..2
- o_Rollover  output  1  one-cycle pulse on full-day wrap
- o_Second_Blink  output  1  toggles on every accepted seconds increment

Behaviour:
- One clock, i_Clock. Reset is synchronous and active-low (i_Reset_n); polarity and synchronicity fixed.
- All outputs are registered.
- Reset values (i_Reset_n = 0 at an edge):
  - seconds 00, minutes 00
  - hours 00 (24h) or 12 (12h)
  - o_Rollover 0, o_Second_Blink 0
- Update priority per edge: i_Reset_n low > i_Counters_Reset > set-mode increment > run-mode count.
- i_Counters_Reset = 1:
  - Seconds forced to 00 every cycle it is high.
  - Minutes and hours hold.
  - No carry and no o_Rollover generated, including when a tick coincides.
- Run mode (Enable_Increment = 0):
  - On i_Tick_1Hz with Enable_Count[0] = 1: seconds +1; o_Second_Blink toggles.
  - Seconds 59 -> 00 carries into minutes if Enable_Count[1].
  - Minutes 59 -> 00 carries into hours if Enable_Count[2].
  - Hours: 23 -> 00 (24h), 12 -> 01 (12h). 11 -> 12 is a normal increment.
  - The whole carry chain resolves in the same edge; the new time is visible the cycle after the tick.
  - i_Tick_Set is ignored.
  - Field with enable 0: holds; any carry into it is dropped, not deferred.
- Set mode (Enable_Increment = 1):
  - i_Tick_1Hz is ignored; o_Second_Blink holds.
  - On i_Tick_Set, every enabled field increments by one with its own wrap (59 -> 00; hours per mode).
  - No carry between fields; o_Rollover never asserted.
- o_Rollover:
  - Asserted exactly one cycle after the edge where the run-mode carry chain wraps hours from the day-end value: 23:59:59 -> 00:00:00, or 11:59:59 -> 12:00:00 in 12h mode.
  - All three enables must be set. Deasserted otherwise.
- BCD digits never leave their legal ranges. Ones digit 9 -> 0 increments the tens digit. Field wraps are compared on the full two-digit value.
- Mode change mid-operation: takes effect on the next edge, no state lost. Enable_Count changes are sampled per edge.
- Reset mid-count: all fields load reset values on that edge; pending ticks are discarded.

Test Plan:
- Reset: hold i_Reset_n = 0 for 2 cycles, ticks pulsing -> 00:00:00, o_Rollover = 0, o_Second_Blink = 0. In 12h mode -> 12:00:00.
- Run count: Enable_Count = 111, 60 i_Tick_1Hz pulses -> 00:01:00. Digits change one cycle after each tick. o_Second_Blink toggles 60 times, ending at 0.
- Day wrap:
  - Set to 23:59:59 via set mode: 23 Tick_Set on hours, 59 on minutes; then run ticks for seconds.
  - One tick -> 00:00:00 with o_Rollover high for exactly 1 cycle.
  - 12h mode: 11:59:59 -> 12:00:00 with o_Rollover; 12:59:59 -> 01:00:00 without o_Rollover.
- Set mode: Enable_Increment = 1, Enable_Count = 010, minutes 59 -> one Tick_Set gives minutes 00, hours unchanged. An interleaved i_Tick_1Hz changes nothing.
- Seconds clear: seconds = 59, minutes = 10; i_Counters_Reset = 1 in the same cycle as i_Tick_1Hz -> seconds 00, minutes 10, no o_Rollover.
- Disabled carry: Enable_Count = 001 at 00:00:59, one tick -> 00:00:00; minutes stay 00 after later Enable_Count = 111.
